if_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage RV32I pipeline; directly upstream of ID.

---
 rtl/if_stage.sv | 133 +++++++++++++
 tb/tb_if_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one fetch outstanding to instruction
// memory and feeds the IF/ID register, with a one-entry skid buffer for ID stalls.
`timescale 1ns/1ps
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        res,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetchPc_q, fetchPc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifIdPc_q, ifIdPc_d;
    logic        valid_q, valid_d;
    logic [31:0] skidInstr_q, skidInstr_d;
    logic [31:0] skidPc_q, skidPc_d;

    // Targets are always word aligned, so the low bits of redirect_pc are dropped.
    logic unusedRedirectLsbs;
    assign unusedRedirectLsbs = ^redirect_pc[1:0];

    // The skid buffer is only ever occupied while in FULL, so no separate valid flag.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetchPc_d   = fetchPc_q;
        instr_d     = instr_q;
        ifIdPc_d    = ifIdPc_q;
        valid_d     = valid_q;
        skidInstr_d = skidInstr_q;
        skidPc_d    = skidPc_q;

        if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ready) begin
                    fetchPc_d = pc_q;
                    pc_d      = pc_q + 32'd4;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (!valid_q || !stall) begin
                        instr_d  = imem_rdata;
                        ifIdPc_d = fetchPc_q;
                        valid_d  = 1'b1;
                        state_d  = REQ;
                    end else begin
                        skidInstr_d = imem_rdata;
                        skidPc_d    = fetchPc_q;
                        state_d     = FULL;
                    end
                end
            end
            FULL: begin
                if (!stall) begin
                    instr_d  = skidInstr_q;
                    ifIdPc_d = skidPc_q;
                    valid_d  = 1'b1;
                    state_d  = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // A redirect wins over everything; a response still owed forces DROP.
        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            case (state_q)
                WAIT:    state_d = imem_rvalid ? REQ : DROP;
                DROP:    state_d = imem_rvalid ? REQ : DROP;
                REQ:     state_d = imem_ready  ? DROP : REQ;
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            fetchPc_q   <= RESET_PC;
            instr_q     <= NOP_INSTR;
            ifIdPc_q    <= 32'h0;
            valid_q     <= 1'b0;
            skidInstr_q <= NOP_INSTR;
            skidPc_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetchPc_q   <= fetchPc_d;
            instr_q     <= instr_d;
            ifIdPc_q    <= ifIdPc_d;
            valid_q     <= valid_d;
            skidInstr_q <= skidInstr_d;
            skidPc_q    <= skidPc_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign if_id_pc    = ifIdPc_q;
    assign if_id_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized traffic, all checked
// against a transaction-level model of the fetch stream and a simple memory model.
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        res;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    int vectors     = 0;
    int miscompares = 0;
    int delivered   = 0;

    // Memory model: one outstanding request, response after memLat cycles.
    bit          pending   = 1'b0;
    logic [31:0] pendAddr  = 32'h0;
    logic [31:0] pendData  = 32'h0;
    int          pendDelay = 0;
    int          memLat    = 1;
    bit          useFixed  = 1'b1;
    logic [31:0] fixedWord = 32'h0050_0093;

    // Fetch-stream model: addresses accepted but not yet handed to ID, in order.
    logic [31:0] qAddr[$];
    logic [31:0] qData[$];
    logic [31:0] expFetch = RESET_PC;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .res(res), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return useFixed ? fixedWord : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        vectors++;
        assert (obs === expd) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expd);
        end
    endtask

    // One clock cycle: memory answers, the edge happens, then the model is advanced.
    task automatic applyStimulus;
        logic        reqW, readyW, redirW, stallW, validW, rvalidW;
        logic [31:0] addrW, rpcW, instrW, pcW, a, d;
        rvalidW     = pending && (pendDelay == 0);
        imem_rvalid = rvalidW;
        imem_rdata  = rvalidW ? pendData : 32'hDEAD_BEEF;
        reqW   = imem_req;
        addrW  = imem_addr;
        readyW = imem_ready;
        redirW = redirect;
        rpcW   = redirect_pc;
        stallW = stall;
        validW = if_id_valid;
        instrW = instruction;
        pcW    = if_id_pc;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;

        if (rvalidW) pending = 1'b0;
        else if (pending) pendDelay--;

        if (reqW && readyW) begin
            checkOutput("acceptAddr", addrW, expFetch);
            pending   = 1'b1;
            pendAddr  = addrW;
            pendData  = memWord(addrW);
            pendDelay = memLat - 1;
            if (!redirW) begin
                qAddr.push_back(addrW);
                qData.push_back(pendData);
            end
            expFetch = addrW + 32'd4;
        end
        if (redirW) begin
            expFetch = {rpcW[31:2], 2'b00};
            qAddr.delete();
            qData.delete();
        end

        if (reqW && !readyW && !redirW) begin
            checkOutput("reqHeld", {31'b0, imem_req}, 32'd1);
            checkOutput("addrHeld", imem_addr, addrW);
        end

        if (redirW) begin
            checkOutput("redirValid", {31'b0, if_id_valid}, 32'd0);
            checkOutput("redirInstr", instruction, NOP);
        end else if (validW && stallW) begin
            checkOutput("holdValid", {31'b0, if_id_valid}, 32'd1);
            checkOutput("holdInstr", instruction, instrW);
            checkOutput("holdPc", if_id_pc, pcW);
        end else if (if_id_valid) begin
            checkOutput("sbNonEmpty", {31'b0, qAddr.size() != 0}, 32'd1);
            if (qAddr.size() != 0) begin
                a = qAddr.pop_front();
                d = qData.pop_front();
                checkOutput("newPc", if_id_pc, a);
                checkOutput("newInstr", instruction, d);
                delivered++;
            end
        end
        if (!if_id_valid) checkOutput("emptyNop", instruction, NOP);
        if (pending || qAddr.size() != 0) checkOutput("oneOutstanding", {31'b0, imem_req}, 32'd0);
    endtask

    task automatic resetPulse;
        res = 1'b1;
        #2;
        checkOutput("rstReq", {31'b0, imem_req}, 32'd0);
        checkOutput("rstAddr", imem_addr, RESET_PC);
        checkOutput("rstValid", {31'b0, if_id_valid}, 32'd0);
        checkOutput("rstInstr", instruction, NOP);
        checkOutput("rstPc", if_id_pc, 32'h0);
        res = 1'b0;
        pending  = 1'b0;
        expFetch = RESET_PC;
        qAddr.delete();
        qData.delete();
    endtask

    initial begin
        res = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        resetPulse();

        // Straight-line fetch with single-cycle memory.
        applyStimulus();
        checkOutput("t1Req", {31'b0, imem_req}, 32'd1);
        checkOutput("t1Addr0", imem_addr, 32'h0);
        applyStimulus();
        useFixed = 1'b0;
        applyStimulus();
        checkOutput("t1Valid", {31'b0, if_id_valid}, 32'd1);
        checkOutput("t1Instr", instruction, 32'h0050_0093);
        checkOutput("t1Pc", if_id_pc, 32'h0);
        checkOutput("t1Addr4", imem_addr, 32'h4);
        applyStimulus();
        applyStimulus();
        checkOutput("t1Pc4", if_id_pc, 32'h4);
        checkOutput("t1Addr8", imem_addr, 32'h8);

        // ID stalls for five cycles; the pc 0x8 word parks in the skid buffer.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("t2HoldPc", if_id_pc, 32'h4);
            checkOutput("t2HoldValid", {31'b0, if_id_valid}, 32'd1);
            if (i >= 1) checkOutput("t2NoReq", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        applyStimulus();
        checkOutput("t2SkidPc", if_id_pc, 32'h8);
        checkOutput("t2SkidValid", {31'b0, if_id_valid}, 32'd1);
        checkOutput("t2AddrC", imem_addr, 32'hC);

        // Redirect while the request at 0xC is not yet accepted.
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        applyStimulus();
        checkOutput("t4Addr", imem_addr, 32'h200);
        checkOutput("t4Req", {31'b0, imem_req}, 32'd1);
        redirect = 1'b0; imem_ready = 1'b1;
        applyStimulus();
        checkOutput("t4NotYet", {31'b0, if_id_valid}, 32'd0);
        applyStimulus();
        checkOutput("t4Pc", if_id_pc, 32'h200);
        checkOutput("t4Valid", {31'b0, if_id_valid}, 32'd1);

        // Redirect while waiting on a two-cycle response; that response is dropped.
        memLat = 2;
        applyStimulus();
        redirect = 1'b1; redirect_pc = 32'h100;
        applyStimulus();
        checkOutput("t3DropReq", {31'b0, imem_req}, 32'd0);
        redirect = 1'b0;
        applyStimulus();
        checkOutput("t3Valid0", {31'b0, if_id_valid}, 32'd0);
        checkOutput("t3Addr", imem_addr, 32'h100);
        memLat = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("t3Pc", if_id_pc, 32'h100);
        checkOutput("t3Instr", instruction, memWord(32'h100));

        // Memory not ready for three cycles at 0x10, then reset mid-WAIT.
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h10;
        applyStimulus();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t5AddrHeld", imem_addr, 32'h10);
        end
        imem_ready = 1'b1; memLat = 2;
        applyStimulus();
        resetPulse();
        memLat = 1;
        applyStimulus();
        checkOutput("t5Refetch", imem_addr, 32'h0);
        checkOutput("t5ReqBack", {31'b0, imem_req}, 32'd1);
        applyStimulus();

        // PC wrap at the top of the address space; target low bits are ignored.
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        applyStimulus();
        checkOutput("t6TopAddr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0; imem_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("t6TopPc", if_id_pc, 32'hFFFF_FFFC);
        checkOutput("t6Wrap", imem_addr, 32'h0);

        // Randomized traffic against the same model.
        for (int c = 0; c < 4000; c++) begin
            stall       = ($urandom_range(0, 9) < 3);
            imem_ready  = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = $urandom;
            memLat      = $urandom_range(1, 3);
            if ($urandom_range(0, 599) == 0) resetPulse();
            applyStimulus();
        end
        redirect = 1'b0;
        checkOutput("deliveredEnough", {31'b0, delivered > 100}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
